// File: rtl/spi_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// spi_pwm_ctrl
//
// Command decoder and 4-channel edge-aligned PWM generator fed by an SPI slave
// receiver. Each completed 16-bit word is announced by rx_valid (SPI clock
// domain). rx_valid is synchronised into CLK, turned into a single write
// strobe, and the word is decoded as a register write. Four PWM outputs are
// produced from a shared period counter.
//
// Word format: [15:14] opcode, [13:12] channel, [11:0] value
//   00 : duty[ch]  <= value
//   01 : period    <= value (channel ignored)
//   10 : enable    <= value[3:0] (applies immediately)
//   11 : invalid, pulses cmd_err, nothing else changes
//
// Build option:
//   PWM_SHADOW_EN defined   : duty/period writes land in staged registers and
//                             are copied to the active set on the period wrap
//                             edge, so a period never mixes old and new values.
//   PWM_SHADOW_EN undefined : writes go straight to the active registers. If a
//                             new period is below the running count, the
//                             counter runs on to all-ones and rolls over.
//
// Ports:
//   CLK          in   1    system clock
//   rst_n        in   1    synchronous active-low reset
//   rx_data      in   16   received word, stable while rx_valid is high
//   rx_valid     in   1    word-complete flag, asynchronous to CLK
//   pwm_out      out  NCH  registered PWM outputs
//   period_wrap  out  1    high while the counter equals the active period
//   cmd_err      out  1    one-cycle pulse on an invalid opcode
// -----------------------------------------------------------------------------
module spi_pwm_ctrl #(
    parameter int NCH = 4,   // channel count, fixed by the 2-bit channel field
    parameter int CW  = 12   // counter, period and duty width
) (
    input  logic           CLK,
    input  logic           rst_n,
    input  logic [15:0]    rx_data,
    input  logic           rx_valid,
    output logic [NCH-1:0] pwm_out,
    output logic           period_wrap,
    output logic           cmd_err
);

    // -------------------------------------------------------------------------
    // Opcodes
    // -------------------------------------------------------------------------
    localparam logic [1:0] OP_DUTY    = 2'b00;
    localparam logic [1:0] OP_PERIOD  = 2'b01;
    localparam logic [1:0] OP_ENABLE  = 2'b10;
    localparam logic [1:0] OP_INVALID = 2'b11;

    localparam logic [CW-1:0] PERIOD_RST = '1;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    // rx_valid synchroniser (s1, s2) and edge-detect delay (s3)
    logic s1_q, s2_q, s3_q;
    logic wr_stb;

    // decoded word fields
    logic [1:0]    op;
    logic [1:0]    ch;
    logic [CW-1:0] value;
    logic          wr_duty;
    logic          wr_period;
    logic          wr_enable;

    // counter and active PWM settings
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  period_act_q, period_act_d;
    logic [CW-1:0]  duty_act_q [NCH];
    logic [CW-1:0]  duty_act_d [NCH];
    logic [NCH-1:0] en_q, en_d;
    logic           wrap;

`ifdef PWM_SHADOW_EN
    // staged settings, copied to the active set at period wrap
    logic [CW-1:0]  period_stg_q, period_stg_d;
    logic [CW-1:0]  duty_stg_q [NCH];
    logic [CW-1:0]  duty_stg_d [NCH];
`endif

    // registered outputs
    logic [NCH-1:0] pwm_q, pwm_d;
    logic           cmd_err_q, cmd_err_d;

    // -------------------------------------------------------------------------
    // CDC: 2-FF synchroniser plus a delay flop. One rx_valid high phase gives
    // exactly one wr_stb cycle (rising edge of the synchronised level).
    // rx_data is not synchronised: it is held stable from the rx_valid rise
    // until the next word, so it has long settled when wr_stb fires.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is always updated with non-blocking
        // assignments so every flop samples the pre-edge value of the others.
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= rx_valid;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign wr_stb = s2_q & ~s3_q;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    assign op    = rx_data[15:14];
    assign ch    = rx_data[13:12];
    assign value = rx_data[CW-1:0];

    assign wr_duty   = wr_stb && (op == OP_DUTY);
    assign wr_period = wr_stb && (op == OP_PERIOD);
    assign wr_enable = wr_stb && (op == OP_ENABLE);

    // -------------------------------------------------------------------------
    // Period counter: counts 0..period_act inclusive. With period_act == 0 the
    // wrap condition holds every cycle and the counter stays at zero.
    // -------------------------------------------------------------------------
    assign wrap = (cnt_q == period_act_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d        = wrap ? '0 : cnt_q + CW'(1);
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        en_d         = wr_enable ? value[NCH-1:0] : en_q;
        cmd_err_d    = wr_stb && (op == OP_INVALID);

`ifdef PWM_SHADOW_EN
        period_stg_d = period_stg_q;
        duty_stg_d   = duty_stg_q;

        if (wr_period) begin
            period_stg_d = value;
        end
        if (wr_duty) begin
            duty_stg_d[ch] = value;
        end

        // The active set loads the pre-edge staged values, so a write landing
        // on the wrap edge itself only becomes active one period later.
        if (wrap) begin
            period_act_d = period_stg_q;
            duty_act_d   = duty_stg_q;
        end
`else
        if (wr_period) begin
            period_act_d = value;
        end
        if (wr_duty) begin
            duty_act_d[ch] = value;
        end
`endif

        // Edge-aligned compare: duty 0 never asserts, duty above the period
        // asserts for the whole period.
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = en_q[i] & (cnt_q < duty_act_q[i]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            period_act_q <= PERIOD_RST;
            en_q         <= '0;
            pwm_q        <= '0;
            cmd_err_q    <= 1'b0;
            // NOTE: the duty arrays are a handful of control registers, not a
            // RAM, so they are reset element by element like any other flop.
            for (int i = 0; i < NCH; i++) begin
                duty_act_q[i] <= '0;
            end
`ifdef PWM_SHADOW_EN
            period_stg_q <= PERIOD_RST;
            for (int i = 0; i < NCH; i++) begin
                duty_stg_q[i] <= '0;
            end
`endif
        end else begin
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            en_q         <= en_d;
            pwm_q        <= pwm_d;
            cmd_err_q    <= cmd_err_d;
`ifdef PWM_SHADOW_EN
            period_stg_q <= period_stg_d;
            duty_stg_q   <= duty_stg_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pwm_out     = pwm_q;
    assign period_wrap = wrap;
    assign cmd_err     = cmd_err_q;

endmodule

// File: doc/spi_pwm_ctrl.md
# spi_pwm_ctrl

Command decoder and 4-channel PWM generator sitting directly downstream of the SPI slave receiver. Takes each completed 16-bit SPI word (data + valid, both in the SPI clock domain), synchronises the valid into the system clock domain, decodes it as a register write, and drives four edge-aligned PWM outputs from a shared 12-bit period counter. Duty/period updates are glitch-free: they take effect at period wrap.

## Interface
Parameters:
- `NCH`, 4: PWM channel count. Fixed at 4; the channel field is 2 bits.
- `CW`, 12: counter, period and duty width.

Ports:
- `CLK`  in  1  system clock. The block has one clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset, sampled on `CLK` rising edge.
- `rx_data`  in  16  word from the SPI slave. Asynchronous to `CLK`, but stable from the `rx_valid` rise until the next word completes.
- `rx_valid`  in  1  word-complete flag from the SPI slave. Asynchronous to `CLK`; each high phase lasts at least 2 `CLK` periods.
- `pwm_out`  out  4  registered PWM outputs.
- `period_wrap`  out  1  one-cycle pulse on the cycle in which the counter equals the active period.
- `cmd_err`  out  1  one-cycle pulse when an invalid opcode is received.

## Operation
- **CDC:** `rx_valid` passes through a 2-FF synchroniser (`s1`, `s2`) plus a delay flop `s3`. `wr_stb = s2 & ~s3`, so one high phase produces exactly one strobe. On `wr_stb`, `rx_data` is sampled directly; it is stable by construction.
- **Word format:**
  - [15:14] opcode.
  - [13:12] channel.
  - [11:0] value.
- **Opcodes:**
  - 00: write staged duty[ch] = value.
  - 01: write staged period = value. The channel field is ignored.
  - 10: write enable mask = value[3:0]. The mask applies immediately.
  - 11: invalid. Pulse `cmd_err` for one cycle; no register changes.
- **Counter `cnt`** (CW bits):
  - Counts 0..period_act inclusive, so a period is period_act+1 cycles.
  - On the cycle with `cnt == period_act`, it wraps to 0 at the next edge.
  - If period_act is 0, `cnt` stays 0 and `period_wrap` is high every cycle.
- **Output:**
  - `pwm_out[i]` next = en[i] & (cnt < duty_act[i]). The compare is unsigned, CW bits.
  - duty 0: constant low.
  - duty > period_act: constant high.
- **Shadow load:** at the edge where `cnt == period_act`, period_act ← period_stg and duty_act[i] ← duty_stg[i].
  - A write landing on that same edge updates staged only. It becomes active at the following wrap.
- **Reset values:**
  - `pwm_out` = 0, `period_wrap` = 0, `cmd_err` = 0.
  - `cnt` = 0.
  - period_stg = period_act = 0xFFF.
  - duty_stg = duty_act = 0.
  - en = 0.
  - `s1`, `s2`, `s3` = 0.
- **Reset mid-word:** a word whose strobe has not yet fired is dropped. A new `rx_valid` rise after reset release is handled normally.
- If `rx_valid` is already high when `rst_n` releases, one strobe fires after 2 cycles. This is accepted behaviour.

## Timing
- Let edge k be the first `CLK` edge sampling `rx_valid`=1 into `s1`.
  - `s2`=1 after edge k+1; `wr_stb` is high during cycle k+1..k+2.
  - The register write or `cmd_err` assertion occurs at edge k+2.
- An enable change is visible on `pwm_out` at edge k+3, since the output is registered.
- A duty/period change is visible on `pwm_out` one edge after the first wrap edge strictly after k+2.
- `period_wrap` is combinational on registered state (`cnt == period_act`). It is high for exactly one cycle per period when period_act > 0.
- Minimum word spacing: 4 `CLK` cycles between `rx_valid` rises. Closer words are not supported.

## Configuration
- `PWM_SHADOW_EN` defined: duty and period use staged/active registers with load at wrap, as above.
- `PWM_SHADOW_EN` undefined:
  - Staged registers are removed; writes go straight to active at edge k+2.
  - If the new period is below the current `cnt`, `cnt` continues counting up to 0xFFF and wraps to 0. This glitch is accepted.
- Enable mask behaviour is identical in both builds.

## Test plan
- **Reset defaults:** hold `rst_n`=0 for 3 cycles, release → `pwm_out`=0, `cnt` free-runs 0..0xFFF, `period_wrap` pulses every 4096 cycles.
- **Basic PWM:** send 0x4009 (period 9), 0x0003 (ch0 duty 3), 0x8001 (en ch0) → after the next wrap, `pwm_out[0]` is high 3 of every 10 cycles and `pwm_out[3:1]`=0.
- **Boundary duty:** with period 9, set ch1 duty 0 and ch2 duty 0x00A (duty > period), send 0x800F → `pwm_out[1]` constant 0, `pwm_out[2]` constant 1, `pwm_out[0]` keeps its prior 3/10 pattern.
- **Glitch-free update (shadow build):** mid-period with `cnt`=5, write ch0 duty 7 → the current period still ends with duty 3; the next period is high for 7 cycles. Also time a write onto the wrap edge → it takes effect one period later.
- **Invalid op + CDC:** send 0xC123 with `rx_valid` held high for 10 `CLK` cycles → exactly one `cmd_err` pulse at edge k+2, all registers unchanged, no second strobe.
- **Reset mid-operation:** assert `rst_n`=0 at edge k+1 of a 0x0005 write → after release, duty0=0, en=0, and no write occurs.
